ploader_frame: RTL
==================

# ploader_frame

Framed, parametrised program loader. Receives a byte stream from the UART receiver, parses a header carrying base address and length, packs payload bytes into DATA_W-bit words with byte strobes, writes them to main memory, then verifies an 8-bit checksum before releasing the core. Sits between the UART RX and the main-memory init port, and drives the core-reset release through DONE. It adds framing, a programmable base address, partial-word flush, timeout and error reporting.

## Interface
- DATA_W, 32: memory write width; 32 or 64.
- MAX_SIZE, 512*1024: maximum payload length in bytes; larger lengths are an error.
- TIMEOUT_CYC, 2**24: maximum number of idle cycles between bytes once a frame has started.
- DONE_DELAY, 128: number of cycles from checksum acceptance to DONE.
- MAGIC, 8'hA5: frame start byte.

- CLK  in  1  clock; the only clock.
- RST_X  in  1  reset; synchronous, active-low.
- RX_DATA  in  8  received byte.
- RX_VALID  in  1  one-cycle strobe; at most one byte per cycle.
- ADDR  out  32  write address; aligned to DATA_W/8.
- WDATA  out  DATA_W  write data, little-endian; unstrobed lanes are 0.
- WSTRB  out  DATA_W/8  byte enables.
- WE  out  1  one-cycle write strobe.
- BUSY  out  1  a frame is in progress (states ADDR through DRAIN).
- DONE  out  1  load succeeded; sticky until reset.
- ERR  out  1  load failed; sticky until reset.
- ERR_CODE  out  2  1 = bad header (misaligned base, or length > MAX_SIZE), 2 = timeout, 3 = checksum mismatch.

## Operation
- Frame format: MAGIC; base address (4 bytes, LSB first); length L in bytes (4 bytes, LSB first); L payload bytes; checksum C = (sum of payload bytes) mod 256.
- States:
  - IDLE. Bytes other than MAGIC are discarded. MAGIC moves to ADDR.
  - ADDR. After 4 bytes, go to LEN.
  - LEN. After 4 bytes, validate the header. If base[log2(DATA_W/8)-1:0] != 0 or L > MAX_SIZE, go to ERROR with code 1. Otherwise go to DATA, or to CSUM if L = 0.
  - DATA. Each byte goes into lane (waddr mod DATA_W/8) and sets that lane's strobe bit. A word is written when its top lane fills, or when the L-th byte arrives (partial flush). Then go to CSUM.
  - CSUM. If the byte equals the running sum, go to DRAIN. Otherwise go to ERROR with code 3.
  - DRAIN. Count DONE_DELAY cycles, then go to DONE.
  - DONE and ERROR are terminal. RX bytes are ignored until reset.
- Write address: ADDR = base + word_index*(DATA_W/8). The byte counter is 32 bits wide; L ≤ MAX_SIZE guarantees it cannot overflow.
- Timeout: in ADDR, LEN, DATA and CSUM, the idle counter resets on every RX_VALID. When it reaches TIMEOUT_CYC, go to ERROR with code 2. A partially filled word is discarded, not written.
- Bytes are counted whether or not WE is still high from the previous word. No back-pressure exists.

## Timing
- Reset value of every output is 0, and the state is IDLE. Reset takes effect in any state, including mid-frame. No write is issued after the reset cycle.
- WE goes high the cycle after the byte that completes a word (or the L-th byte) is accepted. It lasts exactly 1 cycle. ADDR, WDATA and WSTRB are valid while WE=1 and are held until the next write.
- Word buffer and strobes clear in the same cycle WE is raised. Back-to-back bytes therefore produce a WE pulse at most every DATA_W/8 cycles.
- No WE in any cycle after the state leaves DATA.
- DONE rises exactly DONE_DELAY+1 cycles after the checksum byte's RX_VALID cycle.
- ERR rises the cycle after the failing byte, or the cycle after the timeout count is reached. ERR_CODE is valid on that same cycle.
- BUSY rises the cycle after MAGIC is accepted. It falls in the cycle DONE or ERR rises.

## Test plan
- DATA_W=32, frame with base 0x100, L=8, payload 11..18, C=0xA4 → WE at 0x100 with WDATA 0x14131211, WSTRB 0xF; WE at 0x104 with WDATA 0x18171615, WSTRB 0xF; DONE after DONE_DELAY+1 cycles; ERR=0.
- DATA_W=64, base 0x0, L=3, payload AA BB CC, C=0x31 → single WE at 0x0 with WDATA 0x0000000000CCBBAA, WSTRB 0x07; DONE=1.
- Garbage bytes 00 FF before MAGIC; L=0; C=0x00 → no WE; DONE=1.
- DATA_W=32, L=4, payload 01 02 03 04, C=0x0B (correct is 0x0A) → one write at base; ERR=1, ERR_CODE=3; DONE stays 0.
- Base 0x102 → ERR_CODE=1, no WE. Separately, L=MAX_SIZE+1 → ERR_CODE=1.
- Stall of TIMEOUT_CYC cycles after 2 payload bytes → ERR_CODE=2, no WE.
- Reset asserted mid-DATA, then a fresh valid frame → outputs 0 during reset; second frame loads correctly; DONE=1.

Source files
------------

// File: rtl/ploader_frame.sv
// Framed program loader: parses MAGIC/base/length header from the UART byte stream,
// packs payload bytes into strobed memory words, verifies the checksum and releases DONE.
module ploader_frame #(
    parameter int         DATA_W      = 32,
    parameter int         MAX_SIZE    = 512 * 1024,
    parameter int         TIMEOUT_CYC = 2 ** 24,
    parameter int         DONE_DELAY  = 128,
    parameter logic [7:0] MAGIC       = 8'hA5
) (
    input  logic                CLK,
    input  logic                RST_X,
    input  logic [7:0]          RX_DATA,
    input  logic                RX_VALID,
    output logic [31:0]         ADDR,
    output logic [DATA_W-1:0]   WDATA,
    output logic [DATA_W/8-1:0] WSTRB,
    output logic                WE,
    output logic                BUSY,
    output logic                DONE,
    output logic                ERR,
    output logic [1:0]          ERR_CODE
);
    localparam int BPW = DATA_W / 8;
    localparam int LB  = $clog2(BPW);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_LEN, S_DATA, S_CSUM, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       cnt_q, cnt_d;
    logic [31:0]       base_q, base_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       waddr_q, waddr_d;
    logic [31:0]       idle_q, idle_d;
    logic [7:0]        sum_q, sum_d;
    logic [DATA_W-1:0] buf_q, buf_d;
    logic [BPW-1:0]    strb_q, strb_d;
    logic [31:0]       addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic [BPW-1:0]    wstrb_q, wstrb_d;
    logic              we_q, we_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [1:0]        err_code_q, err_code_d;
    logic              last_byte;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        base_d     = base_q;
        len_d      = len_q;
        waddr_d    = waddr_q;
        idle_d     = '0;
        sum_d      = sum_q;
        buf_d      = buf_q;
        strb_d     = strb_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wstrb_d    = wstrb_q;
        we_d       = 1'b0;
        err_code_d = err_code_q;
        last_byte  = (cnt_q == len_q - 32'd1);

        case (state_q)
            S_IDLE: begin
                if (RX_VALID && RX_DATA == MAGIC) begin
                    state_d = S_ADDR;
                    cnt_d   = '0;
                    sum_d   = '0;
                    buf_d   = '0;
                    strb_d  = '0;
                end
            end
            S_ADDR: begin
                if (RX_VALID) begin
                    base_d = {RX_DATA, base_q[31:8]};
                    cnt_d  = cnt_q + 32'd1;
                    if (cnt_q == 32'd3) begin
                        state_d = S_LEN;
                        cnt_d   = '0;
                    end
                end
            end
            S_LEN: begin
                if (RX_VALID) begin
                    len_d = {RX_DATA, len_q[31:8]};
                    cnt_d = cnt_q + 32'd1;
                    if (cnt_q == 32'd3) begin
                        cnt_d   = '0;
                        waddr_d = base_q;
                        if (base_q[LB-1:0] != '0 || len_d > 32'(MAX_SIZE)) begin
                            state_d    = S_ERR;
                            err_code_d = 2'd1;
                        end else if (len_d == '0) begin
                            state_d = S_CSUM;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end
            S_DATA: begin
                if (RX_VALID) begin
                    sum_d   = sum_q + RX_DATA;
                    cnt_d   = cnt_q + 32'd1;
                    waddr_d = waddr_q + 32'd1;
                    for (int i = 0; i < BPW; i++) begin
                        if (waddr_q[LB-1:0] == i[LB-1:0]) begin
                            buf_d[i*8 +: 8] = RX_DATA;
                            strb_d[i]       = 1'b1;
                        end
                    end
                    // A word leaves when its top lane fills or the payload ends mid-word.
                    if ((&waddr_q[LB-1:0]) || last_byte) begin
                        addr_d  = {waddr_q[31:LB], {LB{1'b0}}};
                        wdata_d = buf_d;
                        wstrb_d = strb_d;
                        we_d    = 1'b1;
                        buf_d   = '0;
                        strb_d  = '0;
                    end
                    if (last_byte) state_d = S_CSUM;
                end
            end
            S_CSUM: begin
                if (RX_VALID) begin
                    cnt_d = '0;
                    if (RX_DATA == sum_q) begin
                        state_d = (DONE_DELAY == 0) ? S_DONE : S_DRAIN;
                    end else begin
                        state_d    = S_ERR;
                        err_code_d = 2'd3;
                    end
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + 32'd1;
                if (cnt_q == 32'(DONE_DELAY - 1)) state_d = S_DONE;
            end
            default: ;
        endcase

        // Inter-byte watchdog; any buffered partial word is simply abandoned.
        if (state_q inside {S_ADDR, S_LEN, S_DATA, S_CSUM} && !RX_VALID) begin
            idle_d = idle_q + 32'd1;
            if (idle_d == 32'(TIMEOUT_CYC)) begin
                state_d    = S_ERR;
                err_code_d = 2'd2;
            end
        end

        busy_d = state_d inside {S_ADDR, S_LEN, S_DATA, S_CSUM, S_DRAIN};
        done_d = done_q | (state_d == S_DONE);
        err_d  = err_q | (state_d == S_ERR);
    end

    always_ff @(posedge CLK) begin
        if (!RST_X) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            base_q     <= '0;
            len_q      <= '0;
            waddr_q    <= '0;
            idle_q     <= '0;
            sum_q      <= '0;
            buf_q      <= '0;
            strb_q     <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            we_q       <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            base_q     <= base_d;
            len_q      <= len_d;
            waddr_q    <= waddr_d;
            idle_q     <= idle_d;
            sum_q      <= sum_d;
            buf_q      <= buf_d;
            strb_q     <= strb_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wstrb_q    <= wstrb_d;
            we_q       <= we_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
        end
    end

    assign ADDR     = addr_q;
    assign WDATA    = wdata_q;
    assign WSTRB    = wstrb_q;
    assign WE       = we_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;
    assign ERR      = err_q;
    assign ERR_CODE = err_code_q;
endmodule
